// File: rtl/linreg_pkg.sv
// Shared constants and FSM encoding for the linear-regression sum accumulator.
package linreg_pkg;
    localparam int DATA_W = 20;
    localparam int N      = 150;
    localparam int ADDR_W = 8;
    localparam int SUM_W  = DATA_W + ADDR_W;
    localparam int ACC_W  = 2 * DATA_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/signed_mac.sv
// Signed multiply-accumulate: full-precision a*b sign-extended into a wide accumulator.
module signed_mac
    import linreg_pkg::*;
#(
    parameter int OP_W  = DATA_W,
    parameter int ACC_B = ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    input  logic                    clr,
    input  logic                    en,
    output logic signed [ACC_B-1:0] acc
);
    logic signed [2*OP_W-1:0]  product;
    logic signed [ACC_B-1:0]   productExt;

    assign product    = a * b;
    assign productExt = {{(ACC_B-2*OP_W){product[2*OP_W-1]}}, product};

    // Clear wins over enable so a new pass always starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + productExt;
        end
    end
endmodule

// File: rtl/linreg_sum_accumulator.sv
// Walks the loader memories once per start and accumulates sum x, sum y, sum xy, sum xx.
module linreg_sum_accumulator
    import linreg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] inX,
    input  logic signed [DATA_W-1:0] inY,
    output logic [ADDR_W-1:0]        rdAdr,
    output logic                     busy,
    output logic                     done,
    output logic signed [SUM_W-1:0]  sumX,
    output logic signed [SUM_W-1:0]  sumY,
    output logic signed [ACC_W-1:0]  sumXY,
    output logic signed [ACC_W-1:0]  sumXX
);
    state_t                     stateReg, stateNext;
    logic                       clrSums;
    logic                       lastAdr;
    logic [ADDR_W-1:0]          rdAdrReg;
    logic                       validReg;
    logic signed [DATA_W-1:0]   xReg, yReg;
    logic signed [SUM_W-1:0]    sumXReg, sumYReg;
    logic signed [DATA_W-1:0]   macB   [2];
    logic signed [ACC_W-1:0]    macAcc [2];

    assign lastAdr = (rdAdrReg == ADDR_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // start is only honoured in IDLE; while busy it is simply not looked at.
    always_comb begin
        stateNext = stateReg;
        clrSums   = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    stateNext = READ;
                    clrSums   = 1'b1;
                end
            end
            READ:    if (lastAdr) stateNext = DRAIN;
            DRAIN:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdAdrReg <= '0;
            validReg <= 1'b0;
            xReg     <= '0;
            yReg     <= '0;
        end else begin
            validReg <= (stateReg == READ);
            if (stateReg == READ) begin
                rdAdrReg <= lastAdr ? '0 : rdAdrReg + 1'b1;
                xReg     <= inX;
                yReg     <= inY;
            end else begin
                rdAdrReg <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sumXReg <= '0;
            sumYReg <= '0;
        end else if (clrSums) begin
            sumXReg <= '0;
            sumYReg <= '0;
        end else if (validReg) begin
            sumXReg <= sumXReg + {{(SUM_W-DATA_W){xReg[DATA_W-1]}}, xReg};
            sumYReg <= sumYReg + {{(SUM_W-DATA_W){yReg[DATA_W-1]}}, yReg};
        end
    end

    // Lane 0 forms x*y, lane 1 forms x*x; both share clear and enable.
    assign macB[0] = yReg;
    assign macB[1] = xReg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mac
            signed_mac #(
                .OP_W  (DATA_W),
                .ACC_B (ACC_W)
            ) u_mac (
                .clk (clk),
                .rst (rst),
                .a   (xReg),
                .b   (macB[gi]),
                .clr (clrSums),
                .en  (validReg),
                .acc (macAcc[gi])
            );
        end
    endgenerate

    assign rdAdr = rdAdrReg;
    assign busy  = (stateReg != IDLE);
    assign done  = (stateReg == DONE);
    assign sumX  = sumXReg;
    assign sumY  = sumYReg;
    assign sumXY = macAcc[0];
    assign sumXX = macAcc[1];
endmodule

// File: doc/linreg_sum_accumulator.md
Name: linreg_sum_accumulator

Overview:
- Downstream consumer of the data-loader stage in the linear-regression datapath.
- After the loader has filled its X/Y sample memories, this block walks the read address through all N entries and captures each (x, y) pair.
- It accumulates the four statistics the coefficient stage needs: Σx, Σy, Σxy and Σx².
- It owns the memory read address during its pass and signals completion with a one-cycle done pulse.

Parameters:
- DATA_W, 20, width of each signed two's-complement sample (x and y).
- N, 150, number of samples per pass; matches the loader memory depth.
- ADDR_W, 8, width of the read address; 2^ADDR_W ≥ N.
- SUM_W, 28, width of Σx and Σy (DATA_W + ADDR_W).
- ACC_W, 48, width of Σxy and Σx² (2·DATA_W + ADDR_W).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled each edge; begins a pass when the block is idle.
- inX  in  DATA_W  sample from X memory at rdAdr; combinational read, valid in the same cycle.
- inY  in  DATA_W  sample from Y memory at rdAdr; same timing as inX.
- rdAdr  out  ADDR_W  read address into both loader memories.
- busy  out  1  high from the cycle after start is accepted until done, inclusive.
- done  out  1  one-cycle pulse; all sums are final in that cycle.
- sumX  out  SUM_W  signed Σx.
- sumY  out  SUM_W  signed Σy.
- sumXY  out  ACC_W  signed Σ(x·y).
- sumXX  out  ACC_W  signed Σ(x·x).

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, rdAdr=0, busy=0, done=0, all sums=0, pipeline valid=0. Reset mid-pass aborts the pass with no partial done.
- FSM states IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 at edge t → READ; all sums cleared to 0 at that edge; rdAdr=0.
- READ:
  - Each cycle, the pair (inX, inY) at the current rdAdr is registered into stage-1 with valid=1, and rdAdr increments.
  - At rdAdr=N-1 the address wraps to 0 and the FSM goes to DRAIN.
  - READ occupies exactly N cycles (edges t+1..t+N).
- Stage-2: when the stage-1 valid bit is set:
  - sumX += sx(x), sumY += sx(y), sumXY += x·y, sumXX += x·x, all updated at the same edge.
  - sx() denotes sign extension.
  - Products are full-precision signed 2·DATA_W-bit values, sign-extended to ACC_W. No shifting, rounding or saturation; the fixed-point interpretation belongs to the next stage.
  - Arithmetic wraps modulo the port width. This cannot occur with the default widths and N.
- DRAIN: one cycle; the last stage-1 entry accumulates. Stage-1 valid=0 at exit. → DONE.
- DONE: done=1 for exactly one cycle at cycle t+N+2, and the sums are final. → IDLE.
- busy=1 in READ, DRAIN and DONE.
- Total latency: start-accept edge to done-high is N+2 cycles.
- start while busy is ignored; it neither restarts nor queues.
- start held high continuously: a new pass is accepted in the first IDLE cycle after done.
- Sums hold their values in IDLE until the next accepted start clears them.
- rdAdr holds at 0 outside READ. The block never writes the memories; the loader's write phase must complete before start, and this is the controller's responsibility.

Decomposition:
- Shared package linreg_pkg:
  - Constants DATA_W, N, ADDR_W, SUM_W, ACC_W.
  - FSM state encoding (2-bit: IDLE, READ, DRAIN, DONE).
- One natural sub-module: signed_mac.
  - Inputs: a, b, clr, en.
  - Output: an ACC_W accumulator of a·b.
  - Instantiated twice, once for xy and once for xx.
  - Σx and Σy are plain adders in the top module.

Test Plan:
- All x=1, y=2, start pulse → done at start+152 cycles; sumX=150, sumY=300, sumXY=300, sumXX=150; rdAdr sequence 0..149 then 0.
- Ramp x[i]=i, y[i]=2i+3 → sumX=11175, sumY=22800, sumXY=2261075, sumXX=1113775.
- All x=-524288 (min), y=1 → sumX=-78643200, sumXX=41231686041600, sumXY=-78643200; no overflow.
- start re-pulsed at cycle 50 of a pass → ignored; single done at start+152; sums match a single pass.
- rst low at cycle 80 of a pass → all outputs 0 immediately, no done; new start runs a full correct pass.
- start held high across two passes → done pulses 153 cycles apart; sums cleared between passes; second-pass values match the new memory contents.
